// File: rtl/ncl_q4_injector.sv
// Clocked-to-NCL boundary: buffers 2-bit values and injects them as quad-rail DATA/NULL wavefronts.
// Optional watchdog flag (wdog_err) is enabled by defining NCL_INJ_WDOG_EN.
module ncl_q4_injector #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                         clk,
    input  logic                         init_n,
    input  logic [1:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [3:0]                   Z,
    input  logic                         ZCOMP,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         busy
`ifdef NCL_INJ_WDOG_EN
    ,
    output logic                         wdog_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA      = 2'd1,
        NULL_WAIT = 2'd2
    } state_t;

    // Reject configurations the FIFO pointers and synchronizer cannot support
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2 || TIMEOUT == 0) begin : g_bad_param
        $error("ncl_q4_injector: illegal parameter set");
    end

    state_t                 state_q;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   zs;
    logic [1:0]             mem [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [LW-1:0]          count_nxt;
    logic [1:0]             head;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [3:0]             z_nxt;

    // ZCOMP synchronizer; only the last stage is observed by the FSM
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ZCOMP};
        end
    end

    assign zs    = sync_q[SYNC_STAGES-1];
    assign empty = (level == LW'(0));
    assign head  = mem[rd_ptr_q];
    assign push  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        count_nxt = level;
        if (push && !pop) begin
            count_nxt = level + LW'(1);
        end else if (!push && pop) begin
            count_nxt = level - LW'(1);
        end
    end

    // Pointers and occupancy; in_ready tracks the next occupancy so it is a plain flop
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level    <= count_nxt;
            in_ready <= (count_nxt != LW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:      if (!empty && !zs) state_nxt = DATA;
            DATA:      if (zs)            state_nxt = NULL_WAIT;
            NULL_WAIT: if (!zs)           state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Output decode: only NULL->DATA from IDLE and DATA->NULL from DATA are reachable
    always_comb begin
        pop   = 1'b0;
        z_nxt = Z;
        case (state_q)
            IDLE: begin
                z_nxt = 4'b0000;
                if (!empty && !zs) begin
                    pop   = 1'b1;
                    z_nxt = 4'b0001 << head;
                end
            end
            DATA: begin
                if (zs) begin
                    z_nxt = 4'b0000;
                end
            end
            default: z_nxt = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            Z    <= 4'b0000;
            busy <= 1'b0;
        end else begin
            Z    <= z_nxt;
            busy <= (state_nxt != IDLE);
        end
    end

`ifdef NCL_INJ_WDOG_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q;

    // Dwell counter; the flag sets on the edge the count reaches TIMEOUT and is sticky
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            wd_cnt_q <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (state_nxt != state_q) begin
                wd_cnt_q <= '0;
            end else if (state_q != IDLE && wd_cnt_q != CW'(TIMEOUT)) begin
                wd_cnt_q <= wd_cnt_q + CW'(1);
            end
            if (state_nxt == state_q && state_q != IDLE && wd_cnt_q == CW'(TIMEOUT - 1)) begin
                wdog_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/ncl_q4_injector.md
Name: ncl_q4_injector

Overview:
- Clocked-to-NCL boundary stage that feeds the head of a 1-of-4 (quad-rail) NCL pipeline.
- Accepts 2-bit values through a valid/ready handshake and buffers them in a small FIFO.
- Emits each value as one DATA wavefront (exactly one rail high) followed by a NULL wavefront (all rails low).
- Paces emission from the downstream stage's completion signal ZCOMP, which is asynchronous and is synchronized internally.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- SYNC_STAGES, 2, flops in the ZCOMP synchronizer; minimum 2.
- TIMEOUT, 255, watchdog limit in cycles; used only with NCL_INJ_WDOG_EN.

Ports:
- clk  in  1  single clock.
- init_n  in  1  asynchronous active-low reset.
- in_data  in  2  value to inject, 0..3.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept; equals !full.
- Z  out  4  quad-rail output to the downstream NCL stage; registered.
- ZCOMP  in  1  downstream completion. 1 = downstream holds DATA (request-for-NULL); 0 = downstream holds NULL (request-for-DATA). Asynchronous to clk.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (init_n low, asynchronous):
  - Z=0000 (NULL); FIFO emptied; level=0; FSM=IDLE; synchronizer flops=0; busy=0.
  - in_ready reads 1 during and after reset.
- Push: on a clk edge with in_valid && in_ready, write in_data to the FIFO tail. When full, in_ready=0 and in_valid is ignored.
- Synchronizer: zs = ZCOMP after SYNC_STAGES flops. The FSM uses only zs.
- Encoding: value v drives Z[v]=1 and all other rails 0. Z is driven directly from flops, with no combinational logic after them. Only NULL->DATA and DATA->NULL transitions may occur; a DATA->DATA transition is illegal and must never happen.
- FSM:
  - IDLE: when FIFO non-empty && zs==0, pop the head, set Z=onehot(head), go to DATA. If zs==1, hold Z=0000 and wait; this covers downstream still holding DATA from before reset.
  - DATA: hold Z. When zs==1, set Z=0000 and go to NULL_WAIT.
  - NULL_WAIT: hold Z=0000. When zs==0, go to IDLE. The next pop happens at the earliest on the following edge.
- Latency:
  - Accept at edge k into an empty FIFO, with the FSM in IDLE and zs==0: Z becomes DATA at edge k+1.
  - Downstream rise of ZCOMP: Z returns to NULL SYNC_STAGES+1 edges later.
- Simultaneous push and pop on the same edge: both take effect, level is unchanged, and FIFO order is preserved.
- Push into an empty FIFO and pop of that entry never happen on the same edge; the entry is visible to the FSM from the next edge.
- level updates on the same edge as the push/pop. busy = (state != IDLE).
- Reset mid-wavefront: Z is forced to NULL immediately and all in-flight FIFO contents are discarded. Downstream sees a NULL.

Optional Feature:
- Macro NCL_INJ_WDOG_EN.
- Defined:
  - Adds output port wdog_err (1 bit), reset to 0.
  - A counter clears on every FSM transition and increments each cycle spent in DATA or NULL_WAIT.
  - When the counter reaches TIMEOUT, wdog_err sets and stays at 1 until init_n.
  - The FSM continues to operate normally; the watchdog is a flag only.
- Undefined: no counter and no wdog_err port; all other behaviour is identical.

Test Plan:
- Reset with ZCOMP=0 -> Z=0000, in_ready=1, level=0, busy=0. After release, no Z activity without input.
- Push 2 with ZCOMP=0 -> Z=0100 one edge after accept. Raise ZCOMP -> Z=0000 three edges later (SYNC_STAGES=2). Drop ZCOMP -> busy=0.
- Push 0,1,2,3 back-to-back; model downstream as a responder that sets ZCOMP=OR(Z) after 5 cycles -> Z sequence 0001,0000,0010,0000,0100,0000,1000,0000. A checker confirms exactly one rail high on every DATA and never a DATA->DATA transition.
- Hold ZCOMP=1 and push 5 items with DEPTH=4 -> level=4, in_ready=0, 5th item dropped, Z stays 0000. Release ZCOMP -> the 4 items are emitted in order.
- Assert init_n=0 while Z=1000 -> Z=0000 asynchronously and level=0. After release with ZCOMP=0 -> Z stays 0000.
- NCL_INJ_WDOG_EN with TIMEOUT=10: emit DATA and keep ZCOMP=0 -> wdog_err=1 ten cycles after entering DATA, and it stays 1 after ZCOMP toggles normally.
